mole_game_core: RTL and testbench

//  Parametrised whack-a-mole game engine: round timer, LFSR mole spawner with
//  MAX_MOLES concurrent moles, registered one-shot hit/miss detection, saturating score.

---
 rtl/mole_game_core.sv | 230 +++++++++++++++++++++++
 tb/tb_mole_game_core.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_game_core.sv
// -----------------------------------------------------------------------------
// mole_game_core
//
// Whack-a-mole game engine. It runs a round timer, spawns moles from a 16-bit
// LFSR into MAX_MOLES round-robin slots, turns each key strobe into a one-shot
// hit or miss, and keeps a saturating score.
//
// Strobe semantics: tick_1hz, tick_mole and key_valid are single-cycle strobes.
// Each one is consumed on the clock edge where it is high; there is no
// back-pressure. key_code is only looked at while key_valid is high.
// hit_pulse and miss_pulse are single-cycle outputs on the edge after the
// key strobe, and they never fire together.
//
// Ports
//   clk, rst     system clock, asynchronous active-high reset
//   in_game      game-enable level (already synchronised)
//   tick_1hz     one-cycle strobe per second (round timer)
//   tick_mole    one-cycle strobe per spawn period
//   key_valid    one-cycle strobe per debounced key press
//   key_code     key index, valid with key_valid
//   mole_mask    bit i set while a mole sits in cell i (registered)
//   hit_pulse    one cycle: the key matched a live mole
//   miss_pulse   one cycle: the key during PLAY matched no mole
//   score        current / final score, saturating
//   time_left    seconds remaining in the round
//   game_over    high while in OVER
//   state_dbg    FSM state: 0 = IDLE, 1 = PLAY, 2 = OVER
//
// Build option
//   MOLE_PENALTY_EN : when defined, every miss also takes one point off the
//                     score, saturating at 0.
// -----------------------------------------------------------------------------
module mole_game_core #(
    parameter int          NUM_CELLS = 16,
    parameter int          POS_W     = 4,
    parameter int          MAX_MOLES = 2,
    parameter int          GAME_SECS = 30,
    parameter int          SCORE_W   = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_game,
    input  logic                 tick_1hz,
    input  logic                 tick_mole,
    input  logic                 key_valid,
    input  logic [POS_W-1:0]     key_code,
    output logic [NUM_CELLS-1:0] mole_mask,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [6:0]           time_left,
    output logic                 game_over,
    output logic [1:0]           state_dbg
);

    localparam int                 PTR_W      = (MAX_MOLES > 1) ? $clog2(MAX_MOLES) : 1;
    localparam logic [POS_W:0]     CELL_LIMIT = (POS_W+1)'(NUM_CELLS);
    localparam logic [6:0]         SECS_INIT  = 7'(GAME_SECS);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(MAX_MOLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t               state;
    logic                 in_game_q;
    logic [15:0]          lfsr;
    logic [POS_W-1:0]     slot_cell [MAX_MOLES];
    logic [MAX_MOLES-1:0] slot_valid;
    logic [PTR_W-1:0]     wr_ptr;

    logic [POS_W-1:0]     slot_cell_nxt [MAX_MOLES];
    logic [MAX_MOLES-1:0] slot_valid_nxt;
    logic [PTR_W-1:0]     wr_ptr_nxt;
    logic [NUM_CELLS-1:0] mask_nxt;
    logic [MAX_MOLES-1:0] key_match;
    logic                 cand_clash;

    logic [POS_W-1:0] cand;
    logic             lfsr_fb;
    logic             game_start;
    logic             play_active;
    logic             key_event;
    logic             do_hit;
    logic             do_miss;
    logic             do_spawn;
    logic             final_tick;
    logic             slot_clear;

    assign state_dbg = state;

    // Fibonacci LFSR, taps 16,14,13,11.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign cand    = lfsr[POS_W-1:0];

    assign game_start  = (state == ST_IDLE) && in_game && !in_game_q;
    assign play_active = (state == ST_PLAY) && in_game;

    // Key and spawn decisions are both taken from the slot contents before
    // the edge. A key therefore cannot hit a mole that spawns in the same
    // cycle, but it can hit the old mole in a slot that the spawn overwrites.
    always_comb begin
        key_match  = '0;
        cand_clash = 1'b0;
        for (int i = 0; i < MAX_MOLES; i++) begin
            key_match[i] = slot_valid[i] && (slot_cell[i] == key_code);
            // The slot about to be overwritten does not block its own refill.
            if (slot_valid[i] && (slot_cell[i] == cand) && (PTR_W'(i) != wr_ptr))
                cand_clash = 1'b1;
        end
    end

    assign key_event  = play_active && key_valid && ({1'b0, key_code} < CELL_LIMIT);
    assign do_hit     = key_event && (|key_match);
    assign do_miss    = key_event && !(|key_match);
    assign do_spawn   = play_active && tick_mole && ({1'b0, cand} < CELL_LIMIT) && !cand_clash;
    assign final_tick = play_active && tick_1hz && (time_left == 7'd1);
    assign slot_clear = game_start || ((state == ST_PLAY) && !in_game) || final_tick;

    // Next slot contents. A hit clears its slot first, so a spawn into the
    // same slot in the same cycle leaves the new mole in place.
    always_comb begin
        slot_valid_nxt = slot_valid;
        wr_ptr_nxt     = wr_ptr;
        for (int i = 0; i < MAX_MOLES; i++)
            slot_cell_nxt[i] = slot_cell[i];
        if (slot_clear) begin
            slot_valid_nxt = '0;
            wr_ptr_nxt     = '0;
        end else begin
            if (do_hit)
                slot_valid_nxt = slot_valid & ~key_match;
            if (do_spawn) begin
                slot_valid_nxt[wr_ptr] = 1'b1;
                slot_cell_nxt[wr_ptr]  = cand;
                wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        mask_nxt = '0;
        for (int c = 0; c < NUM_CELLS; c++)
            for (int i = 0; i < MAX_MOLES; i++)
                if (slot_valid_nxt[i] && (slot_cell_nxt[i] == POS_W'(c)))
                    mask_nxt[c] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            in_game_q <= 1'b0;
        end else begin
            lfsr      <= {lfsr[14:0], lfsr_fb};
            in_game_q <= in_game;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            wr_ptr     <= '0;
            mole_mask  <= '0;
            for (int i = 0; i < MAX_MOLES; i++)
                slot_cell[i] <= '0;
        end else begin
            slot_valid <= slot_valid_nxt;
            wr_ptr     <= wr_ptr_nxt;
            mole_mask  <= mask_nxt;
            for (int i = 0; i < MAX_MOLES; i++)
                slot_cell[i] <= slot_cell_nxt[i];
        end
    end

    // Game FSM with registered score, timer and event pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            score      <= '0;
            time_left  <= SECS_INIT;
            game_over  <= 1'b0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= do_hit;
            miss_pulse <= do_miss;
            case (state)
                ST_IDLE: begin
                    if (game_start) begin
                        state     <= ST_PLAY;
                        score     <= '0;
                        time_left <= SECS_INIT;
                    end
                end
                ST_PLAY: begin
                    if (!in_game) begin
                        state <= ST_IDLE;          // abort keeps the score
                    end else begin
                        if (do_hit && (score != SCORE_MAX))
                            score <= score + 1'b1;
`ifdef MOLE_PENALTY_EN
                        else if (do_miss && (score != '0))
                            score <= score - 1'b1;
`endif
                        // The key above is scored before the final tick ends the round.
                        if (tick_1hz) begin
                            time_left <= time_left - 1'b1;
                            if (time_left == 7'd1) begin
                                state     <= ST_OVER;
                                game_over <= 1'b1;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (!in_game) begin
                        state     <= ST_IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_core.sv
// -----------------------------------------------------------------------------
// tb_mole_game_core
//
// Self-checking bench for mole_game_core. A reference model written from the
// game rules follows the DUT cycle by cycle. Every key press the model scores
// pushes the expected {hit, miss, score} into exp_q. A monitor on the falling
// edge pops that queue whenever the DUT shows a pulse, and it also compares
// the mask, score, timer and state on every cycle. Directed scenarios cover
// hit/miss, slot replacement, round end and reset. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mole_game_core;

    localparam int          NUM_CELLS = 16;
    localparam int          POS_W     = 4;
    localparam int          MAX_MOLES = 2;
    localparam int          GAME_SECS = 30;
    localparam int          SCORE_W   = 7;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int          SCORE_MAX = (1 << SCORE_W) - 1;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_OVER = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                 in_game, tick_1hz, tick_mole, key_valid;
    logic [POS_W-1:0]     key_code;
    logic [NUM_CELLS-1:0] mole_mask;
    logic                 hit_pulse, miss_pulse, game_over;
    logic [SCORE_W-1:0]   score;
    logic [6:0]           time_left;
    logic [1:0]           state_dbg;

    mole_game_core #(
        .NUM_CELLS(NUM_CELLS), .POS_W(POS_W), .MAX_MOLES(MAX_MOLES),
        .GAME_SECS(GAME_SECS), .SCORE_W(SCORE_W), .LFSR_SEED(LFSR_SEED)
    ) dut (
        .clk(clk), .rst(rst), .in_game(in_game), .tick_1hz(tick_1hz),
        .tick_mole(tick_mole), .key_valid(key_valid), .key_code(key_code),
        .mole_mask(mole_mask), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .score(score), .time_left(time_left), .game_over(game_over),
        .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state;
    int          m_score;
    int          m_time;
    int          m_ptr;
    int          m_cell [MAX_MOLES];   // -1 = empty slot
    logic [15:0] m_lfsr;
    logic        m_prev;
    int          spawn_log[$];
    logic [SCORE_W+1:0] exp_q[$];      // {hit, miss, score after the key}

    task automatic clear_moles();
        for (int i = 0; i < MAX_MOLES; i++) m_cell[i] = -1;
        m_ptr = 0;
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_score = 0;
        m_time  = GAME_SECS;
        m_lfsr  = LFSR_SEED;
        m_prev  = 1'b0;
        clear_moles();
        exp_q.delete();
    endtask

    task automatic model_step();
        int  cand;
        int  old [MAX_MOLES];
        int  hit_idx;
        bit  clash;
        bit  rise;
        cand   = int'(m_lfsr) % (1 << POS_W);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        rise   = in_game && !m_prev;
        m_prev = in_game;
        old    = m_cell;
        case (m_state)
            S_IDLE: if (rise) begin
                m_state = S_PLAY;
                m_score = 0;
                m_time  = GAME_SECS;
                clear_moles();
            end
            S_PLAY: if (!in_game) begin
                m_state = S_IDLE;
                clear_moles();
            end else begin
                if (key_valid && int'(key_code) < NUM_CELLS) begin
                    hit_idx = -1;
                    for (int i = 0; i < MAX_MOLES; i++)
                        if (old[i] == int'(key_code)) hit_idx = i;
                    if (hit_idx >= 0) begin
                        m_cell[hit_idx] = -1;
                        if (m_score < SCORE_MAX) m_score++;
                        exp_q.push_back({1'b1, 1'b0, SCORE_W'(m_score)});
                    end else begin
`ifdef MOLE_PENALTY_EN
                        if (m_score > 0) m_score--;
`endif
                        exp_q.push_back({1'b0, 1'b1, SCORE_W'(m_score)});
                    end
                end
                if (tick_mole && cand < NUM_CELLS) begin
                    clash = 1'b0;
                    for (int i = 0; i < MAX_MOLES; i++)
                        if (i != m_ptr && old[i] == cand) clash = 1'b1;
                    if (!clash) begin
                        m_cell[m_ptr] = cand;
                        m_ptr = (m_ptr + 1) % MAX_MOLES;
                        spawn_log.push_back(cand);
                    end
                end
                if (tick_1hz) begin
                    m_time--;
                    if (m_time == 0) begin
                        m_state = S_OVER;
                        clear_moles();
                    end
                end
            end
            S_OVER: if (!in_game) m_state = S_IDLE;
            default: m_state = S_IDLE;
        endcase
    endtask

    function automatic logic [NUM_CELLS-1:0] model_mask();
        logic [NUM_CELLS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_MOLES; i++)
            if (m_cell[i] >= 0) m[m_cell[i]] = 1'b1;
        return m;
    endfunction

    function automatic int live_cell();
        int q[$];
        for (int i = 0; i < MAX_MOLES; i++)
            if (m_cell[i] >= 0) q.push_back(m_cell[i]);
        if (q.size() == 0) return -1;
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (hit_pulse && miss_pulse)
                check("pulse_exclusive", 32'({hit_pulse, miss_pulse}), 32'b10);
            if (exp_q.size() > 0)
                check("key_response", 32'({hit_pulse, miss_pulse, score}), 32'(exp_q.pop_front()));
            else
                check("no_pulse", 32'({hit_pulse, miss_pulse}), 32'b00);
            check("mole_mask", 32'(mole_mask), 32'(model_mask()));
            check("score", 32'(score), 32'(m_score));
            check("time_left", 32'(time_left), 32'(m_time));
            check("game_over", 32'(game_over), 32'(m_state == S_OVER));
            check("state", 32'(state_dbg), 32'(m_state));
        end
    end

    // ---------------- driver tasks ----------------
    // Each step starts just after a rising edge and ends just after the next one.
    task automatic step(input logic tm, input logic th, input logic kv, input int kc);
        tick_mole = tm;
        tick_1hz  = th;
        key_valid = kv;
        key_code  = POS_W'(kc);
        @(posedge clk);
        #1;
        tick_mole = 1'b0;
        tick_1hz  = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic start_game();
        in_game = 1'b0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        in_game = 1'b1;
        step(0, 0, 0, 0);
        spawn_log.delete();
    endtask

    task automatic spawn_until(input int target);
        int n = 0;
        while (spawn_log.size() < target && n < 200) begin
            step(1, 0, 0, 0);
            n++;
        end
        check("spawn_count", 32'(spawn_log.size()), 32'(target));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        logic [NUM_CELLS-1:0] exp_m;

        rst = 1'b1;
        in_game = 1'b0; tick_1hz = 1'b0; tick_mole = 1'b0; key_valid = 1'b0; key_code = '0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mask", 32'(mole_mask), 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_time", 32'(time_left), 32'(GAME_SECS));
        check("rst_over", 32'(game_over), 32'h0);
        rst = 1'b0;

        // Start a round: PLAY, score 0, full timer, no moles.
        start_game();
        check("start_state", 32'(state_dbg), 32'(S_PLAY));
        check("start_score", 32'(score), 32'h0);
        check("start_time", 32'(time_left), 32'(GAME_SECS));
        check("start_mask", 32'(mole_mask), 32'h0);

        // Hit a fresh mole, then press the same key again for a miss.
        spawn_until(1);
        c = spawn_log[0];
        check("spawn_bit", 32'(mole_mask[c]), 32'h1);
        step(0, 0, 1, c);
        check("hit_pulse", 32'(hit_pulse), 32'h1);
        check("hit_score", 32'(score), 32'h1);
        check("hit_clears", 32'(mole_mask[c]), 32'h0);
        step(0, 0, 1, c);
        check("miss_pulse", 32'({hit_pulse, miss_pulse}), 32'b01);
`ifdef MOLE_PENALTY_EN
        check("miss_score", 32'(score), 32'h0);
`else
        check("miss_score", 32'(score), 32'h1);
`endif

        // Asynchronous reset in the middle of a round.
        spawn_until(2);
        rst = 1'b1;
        #2;
        check("arst_mask", 32'(mole_mask), 32'h0);
        check("arst_score", 32'(score), 32'h0);
        check("arst_time", 32'(time_left), 32'(GAME_SECS));
        check("arst_state", 32'(state_dbg), 32'(S_IDLE));
        check("arst_pulse", 32'({hit_pulse, miss_pulse}), 32'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Three spawns into two slots: the oldest is replaced.
        start_game();
        spawn_until(3);
        exp_m = '0;
        exp_m[spawn_log[1]] = 1'b1;
        exp_m[spawn_log[2]] = 1'b1;
        check("replace_popcount", 32'($countones(mole_mask)), 32'(MAX_MOLES));
        check("replace_mask", 32'(mole_mask), 32'(exp_m));

        // Run out the clock with a hit on the final tick, then check that OVER is frozen.
        start_game();
        spawn_until(1);
        c = spawn_log[0];
        repeat (GAME_SECS - 1) step(0, 1, 0, 0);
        check("one_sec_left", 32'(time_left), 32'h1);
        step(0, 1, 1, c);
        check("final_hit", 32'(hit_pulse), 32'h1);
        check("final_score", 32'(score), 32'h1);
        check("final_over", 32'(game_over), 32'h1);
        check("final_time", 32'(time_left), 32'h0);
        step(1, 1, 1, c);
        check("over_no_pulse", 32'({hit_pulse, miss_pulse}), 32'b00);
        check("over_frozen", 32'({score, time_left}), 32'({7'd1, 7'd0}));
        in_game = 1'b0;
        step(0, 0, 0, 0);
        check("over_to_idle", 32'(state_dbg), 32'(S_IDLE));

        // Randomized play, including aborts and restarts.
        start_game();
        for (int n = 0; n < 5000; n++) begin
            int kc;
            if (in_game && m_state == S_OVER && $urandom_range(0, 7) == 0)
                in_game = 1'b0;
            else if (!in_game && $urandom_range(0, 5) == 0)
                in_game = 1'b1;
            else if (in_game && m_state == S_PLAY && $urandom_range(0, 499) == 0)
                in_game = 1'b0;
            kc = live_cell();
            if (kc < 0 || $urandom_range(0, 9) < 4)
                kc = $urandom_range(0, NUM_CELLS - 1);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) == 0, kc);
        end

        step(0, 0, 0, 0);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
